// File: rtl/matmul_pkg.sv
// Shared types and widths for the vector x matrix front/back end.
package matmul_pkg;

   localparam int ELEM_W = 20;   // width of one A element
   localparam int ACC_W  = 40;   // width of one C element from the array

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      SEND  = 2'd2
   } seq_state_t;

   // Index width for a dimension of n entries, never narrower than 1 bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_store.sv
// Register array holding matrix A: row-major write pointer with single-element
// writes, and a parallel read of one full row.
module matrix_store
   import matmul_pkg::*;
#(
   parameter int ROWS = 2,
   parameter int COLS = 2
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ELEM_W-1:0]        wr_data,
   output logic                     wr_last,
   input  logic [idx_w(ROWS)-1:0]   rd_row,
   output logic [COLS*ELEM_W-1:0]   rd_data
);

   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);

   logic [RW-1:0]     wr_row_q, wr_row_d;
   logic [CW-1:0]     wr_col_q, wr_col_d;
   logic [ELEM_W-1:0] mem_q [0:ROWS-1][0:COLS-1];

   // Pointer advance: column first, then row; wraps to 0 after the last element.
   always_comb begin
      wr_row_d = wr_row_q;
      wr_col_d = wr_col_q;
      if (wr_en) begin
         if (wr_col_q == CW'(COLS-1)) begin
            wr_col_d = '0;
            wr_row_d = (wr_row_q == RW'(ROWS-1)) ? '0 : wr_row_q + RW'(1);
         end else begin
            wr_col_d = wr_col_q + CW'(1);
         end
      end
   end

   // Pointer register; reset discards any partially loaded matrix.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_row_q <= '0;
         wr_col_q <= '0;
      end else begin
         wr_row_q <= wr_row_d;
         wr_col_q <= wr_col_d;
      end
   end

   // Element storage; contents are kept between passes and simply overwritten.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_row_q][wr_col_q] <= wr_data;
      end
   end

   assign wr_last = (wr_row_q == RW'(ROWS-1)) && (wr_col_q == CW'(COLS-1));

   generate
      for (genvar gi = 0; gi < COLS; gi++) begin : g_rd
         assign rd_data[gi*ELEM_W +: ELEM_W] = mem_q[rd_row][gi];
      end
   endgenerate

endmodule

// File: rtl/matrix_row_sequencer.sv
// Loads matrix A as a stream, presents it row by row to the external
// vector x matrix array, and streams the C = A x B results out.
module matrix_row_sequencer
   import matmul_pkg::*;
#(
   parameter int ROWS     = 2,
   parameter int COLS     = 2,
   parameter int OUT_COLS = 2
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [ELEM_W-1:0]           load_data,
   output logic [COLS*ELEM_W-1:0]      vec_out,
   input  logic [OUT_COLS*ACC_W-1:0]   vals_in,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [ACC_W-1:0]            res_data,
   output logic                        res_row_end,
   output logic                        res_last,
   output logic                        busy
);

   localparam int RW = idx_w(ROWS);
   localparam int KW = idx_w(OUT_COLS);

   seq_state_t               state_q, state_d;
   logic [RW-1:0]            r_q, r_d;
   logic [KW-1:0]            k_q, k_d;
   logic [COLS*ELEM_W-1:0]   vec_out_q, vec_out_d;
   logic [ACC_W-1:0]         res_buf_q [0:OUT_COLS-1];
   logic [ACC_W-1:0]         res_buf_d [0:OUT_COLS-1];
   logic                     load_ready_q, load_ready_d;

   logic                     wr_en;
   logic                     wr_last;
   logic [RW-1:0]            rd_row;
   logic [COLS*ELEM_W-1:0]   rd_data;
   logic [COLS*ELEM_W-1:0]   row0_vec;
   logic                     k_last;
   logic                     r_last;

   assign wr_en  = (state_q == LOAD) && load_valid && load_ready_q;
   assign k_last = (k_q == KW'(OUT_COLS-1));
   assign r_last = (r_q == RW'(ROWS-1));

   // Row read ahead: row 0 while loading, the next row while sending.
   assign rd_row = (state_q == SEND) ? r_q + RW'(1) : '0;

   matrix_store #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (load_data),
      .wr_last (wr_last),
      .rd_row  (rd_row),
      .rd_data (rd_data)
   );

   // Row 0 as seen on the final load edge; with a single row the element
   // being written right now belongs to it and must be forwarded.
   always_comb begin
      row0_vec = rd_data;
      if (ROWS == 1) begin
         row0_vec[(COLS-1)*ELEM_W +: ELEM_W] = load_data;
      end
   end

   // Next-state and datapath updates for the LOAD / ISSUE / SEND sequence.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      k_d       = k_q;
      vec_out_d = vec_out_q;
      res_buf_d = res_buf_q;
      case (state_q)
         LOAD: begin
            if (wr_en && wr_last) begin
               r_d       = '0;
               vec_out_d = row0_vec;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            for (int j = 0; j < OUT_COLS; j++) begin
               res_buf_d[j] = vals_in[j*ACC_W +: ACC_W];
            end
            k_d     = '0;
            state_d = SEND;
         end
         SEND: begin
            if (res_ready) begin
               if (!k_last) begin
                  k_d = k_q + KW'(1);
               end else if (!r_last) begin
                  r_d       = r_q + RW'(1);
                  vec_out_d = rd_data;
                  state_d   = ISSUE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
      load_ready_d = (state_d == LOAD);
   end

   // State and datapath registers; reset abandons any load or send in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LOAD;
         r_q          <= '0;
         k_q          <= '0;
         vec_out_q    <= '0;
         load_ready_q <= 1'b0;
         for (int j = 0; j < OUT_COLS; j++) begin
            res_buf_q[j] <= '0;
         end
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         k_q          <= k_d;
         vec_out_q    <= vec_out_d;
         load_ready_q <= load_ready_d;
         res_buf_q    <= res_buf_d;
      end
   end

   assign load_ready  = load_ready_q;
   assign vec_out     = vec_out_q;
   assign res_valid   = (state_q == SEND);
   assign res_data    = res_buf_q[k_q];
   assign res_row_end = res_valid && k_last;
   assign res_last    = res_row_end && r_last;
   assign busy        = (state_q != LOAD);

endmodule
